// File: rtl/onehot_sequencer.sv
// Registered binary-to-one-hot decoder with handshaked direct loads, an up/down
// scan sequencer with programmable dwell, and a hold mode.
module onehot_sequencer #(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 2**SEL_W,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   D,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_t;

  localparam logic [OUT_W-1:0] ONE_HOT_LSB = OUT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  mode_t              w_mode;
  logic [1:0]         r_mode_prev;
  logic [SEL_W-1:0]   r_idx;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [DWELL_W-1:0] w_cnt_base;
  logic [DWELL_W-1:0] w_dwell_lim;
  logic [OUT_W-1:0]   r_d;
  logic [OUT_W-1:0]   w_d_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;
  logic               w_load;
  logic               w_mode_chg;
  logic               w_expire;

  assign w_mode    = mode_t'(mode);
  assign sel_ready = en & rst_n;
  assign w_load    = sel_valid & sel_ready;

  // A mode change restarts the dwell count and the new mode acts from that zero
  // on the same edge, so a scan position always lasts a full dwell.
  assign w_mode_chg  = (mode != r_mode_prev);
  assign w_cnt_base  = w_mode_chg ? '0 : r_cnt;
  assign w_dwell_lim = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign w_expire    = (w_cnt_base >= w_dwell_lim);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode_prev <= MODE_DIRECT;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_d         <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_prev <= mode;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_d         <= w_d_nxt;
      r_wrap      <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (en)  w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!en) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every signal gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    if (!en) begin
      w_cnt_nxt = '0;
    end else if (w_load) begin
      w_idx_nxt = sel;
      w_cnt_nxt = '0;
    end else if (r_state == ST_IDLE) begin
      // Enable rising edge: show the retained index for a full dwell first.
      w_cnt_nxt = '0;
    end else begin
      case (w_mode)
        MODE_SCAN_UP: begin
          if (w_expire) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = r_idx + SEL_W'(1);
            w_wrap_nxt = (r_idx == '1);
          end else begin
            w_cnt_nxt = w_cnt_base + DWELL_W'(1);
          end
        end
        MODE_SCAN_DOWN: begin
          if (w_expire) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = r_idx - SEL_W'(1);
            w_wrap_nxt = (r_idx == '0);
          end else begin
            w_cnt_nxt = w_cnt_base + DWELL_W'(1);
          end
        end
        MODE_HOLD: w_cnt_nxt = w_cnt_base;
        default:   w_cnt_nxt = '0;
      endcase
    end
    w_d_nxt = en ? (ONE_HOT_LSB << w_idx_nxt) : '0;
  end

  assign D    = r_d;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule
